// File: rtl/pm_line_server_if.sv
// Request, ROM and fill-beat signals of the line server, grouped for port passing.
// slave = server side; master = sequencer/ROM/sink side.
interface pm_line_server_if;
   logic       req_valid;
   logic       req_ready;
   logic [4:0] req_line;
   logic [2:0] req_offset;
   logic [7:0] rom_address;
   logic [7:0] rom_data;
   logic       fill_valid;
   logic       fill_ready;
   logic [7:0] fill_data;
   logic [2:0] fill_offset;
   logic       fill_last;
   logic       busy;

   modport slave (
      input  req_valid, req_line, req_offset, rom_data, fill_ready,
      output req_ready, rom_address, fill_valid, fill_data, fill_offset, fill_last, busy
   );

   modport master (
      output req_valid, req_line, req_offset, rom_data, fill_ready,
      input  req_ready, rom_address, fill_valid, fill_data, fill_offset, fill_last, busy
   );
endinterface

// File: rtl/pm_line_server.sv
// Line-fill server: streams the 8 words of a program line as fill beats (start word via PM_CRITICAL_WORD_FIRST_EN).
// Latency: one FETCH cycle after acceptance, then one beat per cycle (9 cycles to the last beat).
// Backpressure: fill_ready low holds the presented beat and the ROM address; requests are refused while busy.
module pm_line_server (
   input  logic              clk,
   input  logic              sync_reset,
   pm_line_server_if.slave   bus
);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_FETCH  = 2'd1,
      S_STREAM = 2'd2
   } state_t;

   state_t     r_state;
   state_t     w_state_nxt;

   logic [4:0] r_line;
   logic [2:0] r_word;
   logic [2:0] r_beat;
   logic [7:0] r_fill_data;
   logic [2:0] r_fill_offset;

   logic       w_req_acc;
   logic       w_load;
   logic       w_beat_acc;
   logic       w_req_ready;
   logic       w_busy;
   logic       w_fill_valid;
   logic       w_fill_last;
   logic [2:0] w_start;

`ifdef PM_CRITICAL_WORD_FIRST_EN
   assign w_start = bus.req_offset;
`else
   // Offset is deliberately discarded: lines always stream from word 0.
   assign w_start = bus.req_offset & 3'b000;
`endif

   always_ff @(posedge clk) begin
      if (sync_reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt  = r_state;
      w_req_acc    = 1'b0;
      w_load       = 1'b0;
      w_beat_acc   = 1'b0;
      w_req_ready  = 1'b0;
      w_busy       = 1'b0;
      w_fill_valid = 1'b0;
      w_fill_last  = 1'b0;
      case (r_state)
         S_IDLE: begin
            w_req_ready = 1'b1;
            if (bus.req_valid) begin
               w_req_acc   = 1'b1;
               w_state_nxt = S_FETCH;
            end
         end
         S_FETCH: begin
            w_busy      = 1'b1;
            w_load      = 1'b1;
            w_state_nxt = S_STREAM;
         end
         S_STREAM: begin
            w_busy       = 1'b1;
            w_fill_valid = 1'b1;
            w_fill_last  = (r_beat == 3'd7);
            if (bus.fill_ready) begin
               w_beat_acc = 1'b1;
               // The eighth accepted beat closes the line; nothing further is loaded.
               if (r_beat == 3'd7) begin
                  w_state_nxt = S_IDLE;
               end else begin
                  w_load = 1'b1;
               end
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (sync_reset) begin
         r_line        <= 5'd0;
         r_word        <= 3'd0;
         r_beat        <= 3'd0;
         r_fill_data   <= 8'd0;
         r_fill_offset <= 3'd0;
      end else begin
         if (w_req_acc) begin
            r_line <= bus.req_line;
            r_word <= w_start;
            r_beat <= 3'd0;
         end
         if (w_load) begin
            r_fill_data   <= bus.rom_data;
            r_fill_offset <= r_word;
            r_word        <= r_word + 3'd1;
         end
         if (w_beat_acc && !w_fill_last) begin
            r_beat <= r_beat + 3'd1;
         end
      end
   end

   assign bus.req_ready   = w_req_ready;
   assign bus.busy        = w_busy;
   assign bus.fill_valid  = w_fill_valid;
   assign bus.fill_last   = w_fill_last;
   assign bus.fill_data   = r_fill_data;
   assign bus.fill_offset = r_fill_offset;
   assign bus.rom_address = {r_line, r_word};

endmodule

// File: tb/tb_pm_line_server.sv
// Bench for pm_line_server: random ROM image, directed and random line requests,
// each beat compared with a reference computed from line/offset arithmetic.
module tb_pm_line_server;

   logic clk = 1'b0;
   logic sync_reset;
   int   cyc    = 0;
   int   n_chk  = 0;
   int   n_fail = 0;
   logic [7:0] rom_mem [256];

   pm_line_server_if bus ();

   pm_line_server dut (
      .clk        (clk),
      .sync_reset (sync_reset),
      .bus        (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   assign bus.rom_data = rom_mem[bus.rom_address];

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "time limit");
   end

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic int start_word(input int off);
`ifdef PM_CRITICAL_WORD_FIRST_EN
      return off;
`else
      return 0;
`endif
   endfunction

   task automatic check_beat(input int i, input int ln, input int o);
      chk($sformatf("b%0d_valid", i), bus.fill_valid, 1);
      chk($sformatf("b%0d_data", i), bus.fill_data, rom_mem[ln * 8 + o]);
      chk($sformatf("b%0d_offset", i), bus.fill_offset, o);
      chk($sformatf("b%0d_last", i), bus.fill_last, (i == 7) ? 1 : 0);
      chk($sformatf("b%0d_addr", i), bus.rom_address, ln * 8 + (o + 1) % 8);
      chk($sformatf("b%0d_ready", i), bus.req_ready, 0);
   endtask

   // Called at a negedge; returns the cycle count of the accepting edge.
   task automatic accept_req(input int ln, input int off, output int acc);
      int n;
      bus.req_line   = ln[4:0];
      bus.req_offset = off[2:0];
      bus.req_valid  = 1'b1;
      n = 0;
      while (!bus.req_ready && n < 64) begin
         @(negedge clk);
         n++;
      end
      chk("req_ready_before_accept", bus.req_ready, 1);
      chk("idle_before_accept", bus.busy, 0);
      @(posedge clk);
      #1;
      acc = cyc;
      bus.req_valid  = 1'b0;
      bus.req_line   = 5'($urandom);
      bus.req_offset = 3'($urandom);
   endtask

   task automatic serve(input int ln, input int off, input int acc,
                        input int stall_at, input int stall_n, input int rst_at);
      int start;
      int o;
      int exp_cyc;
      start = start_word(off);
      @(negedge clk);
      chk("fetch_valid", bus.fill_valid, 0);
      chk("fetch_busy", bus.busy, 1);
      chk("fetch_ready", bus.req_ready, 0);
      chk("fetch_addr", bus.rom_address, ln * 8 + start);
      exp_cyc = acc + 1;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         o = (start + i) % 8;
         chk($sformatf("b%0d_cycle", i), 16'(cyc), 16'(exp_cyc));
         check_beat(i, ln, o);
         if (i == rst_at) begin
            sync_reset = 1'b1;
            @(posedge clk);
            #1;
            sync_reset = 1'b0;
            @(negedge clk);
            chk("abort_valid", bus.fill_valid, 0);
            chk("abort_last", bus.fill_last, 0);
            chk("abort_busy", bus.busy, 0);
            chk("abort_ready", bus.req_ready, 1);
            chk("abort_addr", bus.rom_address, 0);
            return;
         end
         if (i == stall_at) begin
            bus.fill_ready = 1'b0;
            for (int k = 0; k < stall_n; k++) begin
               @(negedge clk);
               check_beat(i, ln, o);
            end
            bus.fill_ready = 1'b1;
            exp_cyc += stall_n;
         end
         exp_cyc++;
      end
      @(negedge clk);
      chk("end_valid", bus.fill_valid, 0);
      chk("end_last", bus.fill_last, 0);
      chk("end_busy", bus.busy, 0);
      chk("end_ready", bus.req_ready, 1);
   endtask

   initial begin
      int acc;
      int ln;
      int off;
      int st;
      for (int a = 0; a < 256; a++) rom_mem[a] = 8'($urandom);
      sync_reset     = 1'b1;
      bus.req_valid  = 1'b0;
      bus.req_line   = 5'd0;
      bus.req_offset = 3'd0;
      bus.fill_ready = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      sync_reset = 1'b0;
      chk("rst_ready", bus.req_ready, 1);
      chk("rst_busy", bus.busy, 0);
      chk("rst_valid", bus.fill_valid, 0);
      chk("rst_addr", bus.rom_address, 8'h00);
      chk("rst_data", bus.fill_data, 0);
      chk("rst_offset", bus.fill_offset, 0);
      chk("rst_last", bus.fill_last, 0);
      @(negedge clk);
      chk("idle_busy", bus.busy, 0);
      chk("idle_addr", bus.rom_address, 8'h00);

      accept_req(5'h03, 0, acc);
      serve(5'h03, 0, acc, -1, 0, -1);

      accept_req(5'h1F, 6, acc);
      serve(5'h1F, 6, acc, -1, 0, -1);

      accept_req(5'h0A, 3, acc);
      serve(5'h0A, 3, acc, 1, 3, -1);

      accept_req(5'h07, 2, acc);
      serve(5'h07, 2, acc, -1, 0, 3);
      accept_req(5'h07, 2, acc);
      serve(5'h07, 2, acc, -1, 0, -1);

      // A request coinciding with reset must be dropped.
      bus.req_line   = 5'h11;
      bus.req_offset = 3'd1;
      bus.req_valid  = 1'b1;
      sync_reset     = 1'b1;
      @(posedge clk);
      #1;
      sync_reset    = 1'b0;
      bus.req_valid = 1'b0;
      @(negedge clk);
      chk("rst_req_busy", bus.busy, 0);
      chk("rst_req_valid", bus.fill_valid, 0);

      accept_req(5'h14, 4, acc);
      bus.req_line   = 5'h15;
      bus.req_offset = 3'd1;
      bus.req_valid  = 1'b1;
      serve(5'h14, 4, acc, -1, 0, -1);
      accept_req(5'h15, 1, acc);
      serve(5'h15, 1, acc, -1, 0, -1);

      for (int r = 0; r < 10; r++) begin
         ln  = $urandom_range(0, 31);
         off = $urandom_range(0, 7);
         st  = ($urandom_range(0, 1) == 1) ? $urandom_range(0, 7) : -1;
         accept_req(ln, off, acc);
         serve(ln, off, acc, st, $urandom_range(1, 3), -1);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
